// File: rtl/pio_fetch_unit.sv
// pio_fetch_unit: instruction fetch and sequencing for one PIO state machine.
// Holds the current instruction for execute, drives the instruction memory
// read address and advances the program counter.
// The program counter handles wrap, jumps, stalls and per-instruction delay cycles.
module pio_fetch_unit #(
  parameter int ADDR_W       = 5,
  parameter int INSTR_W      = 16,
  parameter int SIDESET_BITS = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               restart,
  input  logic [ADDR_W-1:0]  wrap_top,
  input  logic [ADDR_W-1:0]  wrap_bottom,
  input  logic               stall,
  input  logic               jmp_valid,
  input  logic [ADDR_W-1:0]  jmp_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               delaying
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DELAY
  } state_e;

  // Side-set bits occupy the top of instr[12:8]; the delay count is whatever is left below them.
  localparam logic [4:0] DELAY_MASK = 5'h1f >> SIDESET_BITS;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic [4:0]          cnt_q, cnt_d;

  logic                accept;
  logic [4:0]          delay_field;
  logic [ADDR_W-1:0]   seq_addr;
  logic [ADDR_W-1:0]   next_addr;

  // Retire decision, delay extraction and the address that follows the held instruction.
  always_comb begin
    accept      = (state_q == ST_RUN) && instr_valid_q && enable && !stall && !restart;
    delay_field = instr_q[12:8] & DELAY_MASK;
    seq_addr    = (pc_q == wrap_top) ? wrap_bottom : pc_q + ADDR_W'(1);
    next_addr   = jmp_valid ? jmp_target : seq_addr;
  end

  // Next-state logic: restart beats a disabled machine, which beats normal sequencing.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    cnt_d         = cnt_q;
    if (restart) begin
      state_d       = ST_IDLE;
      pc_d          = '0;
      instr_valid_d = 1'b0;
      cnt_d         = '0;
    end else if (!enable) begin
      state_d       = ST_IDLE;
      instr_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          instr_d       = imem_data;
          instr_valid_d = 1'b1;
          state_d       = ST_RUN;
        end
        ST_RUN: begin
          if (accept) begin
            pc_d = next_addr;
            if (delay_field == 5'd0) begin
              instr_d       = imem_data;
              instr_valid_d = 1'b1;
            end else begin
              instr_valid_d = 1'b0;
              cnt_d         = delay_field;
              state_d       = ST_DELAY;
            end
          end
        end
        ST_DELAY: begin
          if (cnt_q > 5'd1) begin
            cnt_d = cnt_q - 5'd1;
          end else begin
            instr_d       = imem_data;
            instr_valid_d = 1'b1;
            cnt_d         = '0;
            state_d       = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      cnt_q         <= cnt_d;
    end
  end

  assign imem_addr   = accept ? next_addr : pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign delaying    = (state_q == ST_DELAY);

endmodule

// File: tb/tb_pio_fetch_unit.sv
// tb_pio_fetch_unit: drives two fetch units (no side-set and two side-set bits)
// from one instruction memory and checks them against a cycle-level reference model.
module tb_pio_fetch_unit;
  localparam int AW = 5;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          restart = 1'b0;
  logic          stall = 1'b0;
  logic          jmp_valid = 1'b0;
  logic [AW-1:0] wrap_top = 5'd31;
  logic [AW-1:0] wrap_bottom = 5'd0;
  logic [AW-1:0] jmp_target = 5'd0;
  logic [IW-1:0] mem [0:31];

  logic [AW-1:0] addr0, addr1, pc0, pc1;
  logic [IW-1:0] data0, data1, instr0, instr1;
  logic          v0, v1, dl0, dl1;

  assign data0 = mem[addr0];
  assign data1 = mem[addr1];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, one slot per instance.
  int            ss [2] = '{0, 2};
  logic [AW-1:0] m_pc [2];
  logic [IW-1:0] m_instr [2];
  bit            m_valid [2];
  bit            m_run [2];
  int            m_bub [2];

  pio_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .SIDESET_BITS(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .wrap_top(wrap_top), .wrap_bottom(wrap_bottom), .stall(stall),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target), .imem_addr(addr0),
    .imem_data(data0), .instr(instr0), .instr_valid(v0), .pc(pc0), .delaying(dl0)
  );

  pio_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .SIDESET_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .wrap_top(wrap_top), .wrap_bottom(wrap_bottom), .stall(stall),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target), .imem_addr(addr1),
    .imem_data(data1), .instr(instr1), .instr_valid(v1), .pc(pc1), .delaying(dl1)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Runaway guard.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic int delay_of(logic [IW-1:0] w, int s);
    int f;
    f = int'(w[12:8]);
    if (s >= 5) return 0;
    return f % (1 << (5 - s));
  endfunction

  function automatic logic [AW-1:0] seq_of(logic [AW-1:0] a);
    if (a == wrap_top) return wrap_bottom;
    return AW'((int'(a) + 1) % 32);
  endfunction

  function automatic bit m_accept(int k);
    return m_run[k] && (m_bub[k] == 0) && m_valid[k] && enable && !stall && !restart;
  endfunction

  function automatic logic [AW-1:0] m_next(int k);
    return jmp_valid ? jmp_target : seq_of(m_pc[k]);
  endfunction

  // Layout: pc[27:23] instr[22:7] valid[6] delaying[5] imem_addr[4:0]
  function automatic logic [27:0] exp_vec(int k);
    logic [AW-1:0] a;
    logic          d;
    a = m_accept(k) ? m_next(k) : m_pc[k];
    d = m_run[k] && (m_bub[k] > 0);
    return {m_pc[k], m_instr[k], m_valid[k], d, a};
  endfunction

  function automatic logic [27:0] obs_vec(int k);
    if (k == 0) return {pc0, instr0, v0, dl0, addr0};
    return {pc1, instr1, v1, dl1, addr1};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = '0;
      m_instr[k] = '0;
      m_valid[k] = 1'b0;
      m_run[k] = 1'b0;
      m_bub[k] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied, then move to the next falling edge.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      if (restart) begin
        m_pc[k] = '0; m_valid[k] = 1'b0; m_bub[k] = 0; m_run[k] = 1'b0;
      end else if (!enable) begin
        m_run[k] = 1'b0; m_valid[k] = 1'b0; m_bub[k] = 0;
      end else if (!m_run[k]) begin
        m_instr[k] = mem[m_pc[k]]; m_valid[k] = 1'b1; m_run[k] = 1'b1;
      end else if (m_bub[k] > 0) begin
        m_bub[k]--;
        if (m_bub[k] == 0) begin
          m_instr[k] = mem[m_pc[k]]; m_valid[k] = 1'b1;
        end
      end else if (!stall) begin
        logic [AW-1:0] n;
        int d;
        n = m_next(k);
        d = delay_of(m_instr[k], ss[k]);
        m_pc[k] = n;
        if (d == 0) begin
          m_instr[k] = mem[n]; m_valid[k] = 1'b1;
        end else begin
          m_valid[k] = 1'b0; m_bub[k] = d;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic fill_mem_zero_delay();
    for (int i = 0; i < 32; i++) begin
      mem[i] = IW'($urandom);
      mem[i][12:8] = 5'd0;
    end
  endtask

  task automatic test_reset();
    bit found;
    fill_mem_zero_delay();
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs_vec(k) !== exp_vec(k)) begin
        miscompares++;
        $display("[TB] FAIL reset.por inst%0d got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem[0][12:8] = 5'd5;
    for (int c = 0; c < 2; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("[TB] FAIL reset.idle inst%0d got %h want %h", k, obs_vec(k), exp_vec(k));
        end
      end
      step();
    end
    enable = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("[TB] FAIL reset.to_delay inst%0d got %h want %h", k, obs_vec(k), exp_vec(k));
        end
      end
      if (m_bub[0] == 3) found = 1'b1;
      else step();
    end
    vectors++;
    if (!found || dl0 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset.reach_delay got delaying=%b want 1", dl0);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({v0, dl0, pc0, addr0, instr0, v1, dl1, pc1, addr1, instr1} !== 56'd0) begin
      miscompares++;
      $display("[TB] FAIL reset.async got v=%b/%b dl=%b/%b pc=%0d/%0d addr=%0d/%0d want all 0",
               v0, v1, dl0, dl1, pc0, pc1, addr0, addr1);
    end
    model_reset();
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) enable = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("[TB] FAIL reset.resume inst%0d cyc%0d got %h want %h", k, c, obs_vec(k), exp_vec(k));
        end
      end
      step();
    end
  endtask

  task automatic test_wrap();
    int exp_pcs [8] = '{0, 1, 2, 3, 1, 2, 3, 1};
    fill_mem_zero_delay();
    restart = 1'b1; enable = 1'b0;
    step();
    restart = 1'b0; enable = 1'b1; stall = 1'b0; jmp_valid = 1'b0;
    wrap_bottom = 5'd1; wrap_top = 5'd3;
    for (int i = 0; i < 9; i++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("[TB] FAIL wrap.model inst%0d cyc%0d got %h want %h", k, i, obs_vec(k), exp_vec(k));
        end
      end
      if (i >= 1) begin
        vectors++;
        if (pc0 !== AW'(exp_pcs[i-1]) || v0 !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL wrap.pc cyc%0d got pc=%0d v=%b want pc=%0d v=1", i, pc0, v0, exp_pcs[i-1]);
        end
      end
      step();
    end
    wrap_bottom = 5'd0; wrap_top = 5'd31;
  endtask

  task automatic test_jump();
    fill_mem_zero_delay();
    restart = 1'b1; enable = 1'b0;
    step();
    restart = 1'b0; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      jmp_valid = (i == 3);
      jmp_target = 5'd9;
      #1;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("[TB] FAIL jump.model inst%0d cyc%0d got %h want %h", k, i, obs_vec(k), exp_vec(k));
        end
      end
      if (i == 3) begin
        vectors++;
        if (pc0 !== 5'd2 || addr0 !== 5'd9) begin
          miscompares++;
          $display("[TB] FAIL jump.addr got pc=%0d addr=%0d want pc=2 addr=9", pc0, addr0);
        end
      end
      if (i == 4) begin
        vectors++;
        if (pc0 !== 5'd9 || instr0 !== mem[9] || v0 !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL jump.land got pc=%0d instr=%h v=%b want pc=9 instr=%h v=1", pc0, instr0, v0, mem[9]);
        end
      end
      step();
    end
    jmp_valid = 1'b0;
  endtask

  task automatic test_delay();
    for (int pass = 0; pass < 2; pass++) begin
      int phase;
      int zeros;
      logic [27:0] o;
      fill_mem_zero_delay();
      mem[0][12:8] = (pass == 0) ? 5'd3 : 5'b11011;
      restart = 1'b1; enable = 1'b0;
      step();
      restart = 1'b0; enable = 1'b1;
      phase = 0; zeros = 0;
      for (int c = 0; c < 40; c++) begin
        #1;
        for (int k = 0; k < 2; k++) begin
          vectors++;
          if (obs_vec(k) !== exp_vec(k)) begin
            miscompares++;
            $display("[TB] FAIL delay.model pass%0d inst%0d cyc%0d got %h want %h", pass, k, c, obs_vec(k), exp_vec(k));
          end
        end
        o = obs_vec(pass);
        if (phase == 0 && o[6] && o[22:7] === mem[0]) phase = 1;
        else if (phase == 1 && !o[6]) begin
          zeros++;
          if (!o[5]) zeros = 100;
        end else if (phase == 1 && o[6]) begin
          phase = 2;
          vectors++;
          if (zeros != 3 || o[22:7] !== mem[1]) begin
            miscompares++;
            $display("[TB] FAIL delay.gap pass%0d got %0d bubbles instr=%h want 3 bubbles instr=%h", pass, zeros, o[22:7], mem[1]);
          end
        end
        step();
      end
      if (phase != 2) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL delay.timeout pass%0d got phase %0d want 2", pass, phase);
      end
    end
  endtask

  task automatic test_stall();
    fill_mem_zero_delay();
    restart = 1'b1; enable = 1'b0;
    step();
    restart = 1'b0; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("[TB] FAIL stall.pre inst%0d cyc%0d got %h want %h", k, i, obs_vec(k), exp_vec(k));
        end
      end
      step();
    end
    stall = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      vectors++;
      if (pc0 !== 5'd4 || instr0 !== mem[4] || v0 !== 1'b1 || pc1 !== 5'd4 || v1 !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL stall.hold cyc%0d got pc=%0d instr=%h v=%b want pc=4 instr=%h v=1", s, pc0, instr0, v0, mem[4]);
      end
      if (s < 4) step();
    end
    stall = 1'b0;
    step();
    #1;
    vectors++;
    if (pc0 !== 5'd5 || instr0 !== mem[5] || v0 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall.release got pc=%0d instr=%h v=%b want pc=5 instr=%h v=1", pc0, instr0, v0, mem[5]);
    end
  endtask

  task automatic test_enable_restart();
    fill_mem_zero_delay();
    restart = 1'b1; enable = 1'b0;
    step();
    restart = 1'b0; enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 7) enable = 1'b0;
      if (i == 8) enable = 1'b1;
      if (i == 9) restart = 1'b1;
      if (i == 10) restart = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("[TB] FAIL enrst.model inst%0d cyc%0d got %h want %h", k, i, obs_vec(k), exp_vec(k));
        end
      end
      if (i == 8) begin
        vectors++;
        if (v0 !== 1'b0 || pc0 !== 5'd6) begin
          miscompares++;
          $display("[TB] FAIL enrst.disable got v=%b pc=%0d want v=0 pc=6", v0, pc0);
        end
      end
      if (i == 9) begin
        vectors++;
        if (v0 !== 1'b1 || pc0 !== 5'd6 || instr0 !== mem[6]) begin
          miscompares++;
          $display("[TB] FAIL enrst.refetch got v=%b pc=%0d instr=%h want v=1 pc=6 instr=%h", v0, pc0, instr0, mem[6]);
        end
      end
      if (i == 10) begin
        vectors++;
        if (v0 !== 1'b0 || pc0 !== 5'd0) begin
          miscompares++;
          $display("[TB] FAIL enrst.restart got v=%b pc=%0d want v=0 pc=0", v0, pc0);
        end
      end
      if (i == 11) begin
        vectors++;
        if (v0 !== 1'b1 || pc0 !== 5'd0 || instr0 !== mem[0]) begin
          miscompares++;
          $display("[TB] FAIL enrst.first got v=%b pc=%0d instr=%h want v=1 pc=0 instr=%h", v0, pc0, instr0, mem[0]);
        end
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 32; i++) begin
      mem[i] = IW'($urandom);
      case ($urandom_range(0, 7))
        0, 1, 2, 3: mem[i][12:8] = 5'd0;
        4:          mem[i][12:8] = 5'b11001;
        default:    mem[i][12:8] = 5'($urandom_range(1, 6));
      endcase
    end
    for (int c = 0; c < 400; c++) begin
      restart    = ($urandom_range(0, 49) == 0);
      enable     = ($urandom_range(0, 9) != 0);
      stall      = ($urandom_range(0, 3) == 0);
      jmp_valid  = ($urandom_range(0, 6) == 0);
      jmp_target = AW'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        wrap_top    = AW'($urandom);
        wrap_bottom = AW'($urandom);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("[TB] FAIL random inst%0d cyc%0d got %h want %h", k, c, obs_vec(k), exp_vec(k));
        end
      end
      step();
    end
    restart = 1'b0; stall = 1'b0; jmp_valid = 1'b0;
    wrap_top = 5'd31; wrap_bottom = 5'd0;
  endtask

  // Scenario sequence and final summary.
  initial begin
    test_reset();
    test_wrap();
    test_jump();
    test_delay();
    test_stall();
    test_enable_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pio_fetch_unit.md
# pio_fetch_unit

Instruction fetch/sequencing stage for one PIO state machine. Drives the read address of `instruction_regfile`, captures the returned instruction into a registered output for the execute stage, and advances the program counter with wrap, jump, stall and per-instruction delay-cycle handling. It sits between the instruction register file (upstream) and the decode/execute logic (downstream).

## Interface
- `ADDR_W`, 5: instruction address width; memory depth is 2^ADDR_W.
- `INSTR_W`, 16: instruction width.
- `SIDESET_BITS`, 0: number of bits of the [12:8] field used for side-set, 0..5. Delay field is instr[12-SIDESET_BITS:8]; with 5 there is no delay field and delay is 0.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  state machine runs when 1.
- `restart`  in  1  synchronous one-cycle restart pulse.
- `wrap_top`  in  ADDR_W  last address before wrap.
- `wrap_bottom`  in  ADDR_W  address following `wrap_top`.
- `stall`  in  1  execute stage cannot retire the held instruction this cycle.
- `jmp_valid`  in  1  held instruction resolves as a taken jump (qualified by accept).
- `jmp_target`  in  ADDR_W  jump destination.
- `imem_addr`  out  ADDR_W  combinational read address to `instruction_regfile`.
- `imem_data`  in  INSTR_W  combinational read data from `instruction_regfile`.
- `instr`  out  INSTR_W  registered instruction presented to execute.
- `instr_valid`  out  1  `instr` is valid.
- `pc`  out  ADDR_W  address of `instr` (or, in DELAY, of the next instruction to fetch).
- `delaying`  out  1  high while in DELAY.

## Operation
- States: IDLE, RUN, DELAY. The delay counter `cnt` is 5 bits.
- accept = RUN & instr_valid & enable & ~stall & ~restart.
- seq(a) = (a == wrap_top) ? wrap_bottom : a+1, modulo 2^ADDR_W (max address increments to 0). `wrap_top`/`wrap_bottom` are sampled when used.
- nxt = jmp_valid ? jmp_target : seq(pc). `jmp_valid` is ignored unless accept.
- d = delay field of the held `instr`.
- `imem_addr` = (RUN & accept) ? nxt : pc.
- Priority per edge is restart, then ~enable, then state action.
- restart: pc<=0, instr_valid<=0, cnt<=0, state<=IDLE.
- ~enable in RUN or DELAY: state<=IDLE, instr_valid<=0; pc and cnt are held. A pending delay is discarded. The unaccepted instruction at pc is refetched on resume.
- IDLE & enable: instr<=imem_data, instr_valid<=1, state<=RUN.
- RUN & accept & d==0: pc<=nxt, instr<=imem_data, instr_valid<=1.
- RUN & accept & d>0: pc<=nxt, instr_valid<=0, cnt<=d, state<=DELAY.
- RUN & ~accept (stall): all registers hold.
- DELAY & cnt>1: cnt<=cnt-1.
- DELAY & cnt==1: instr<=imem_data, instr_valid<=1, cnt<=0, state<=RUN.
- `stall` has no effect in DELAY or IDLE.
- `delaying` = (state==DELAY).

## Timing
- Reset values: state IDLE; pc 0; instr 0; instr_valid 0; cnt 0; delaying 0. `imem_addr` is therefore 0.
- First `instr_valid` is 1 cycle after `enable` is sampled high in IDLE.
- Back-to-back throughput is one instruction per cycle when d==0 and there is no stall. There is no bubble on a jump.
- An accepted instruction with delay d gives exactly d cycles of instr_valid=0 before the next instruction.
- `imem_data` must settle combinationally within the cycle. `instruction_regfile` writes to the address being fetched are seen on the edge after the write.
- Stall is held indefinitely with no loss.

## Test plan
- Reset: assert `rst_n`=0 mid-DELAY with cnt=3 -> instr_valid=0, pc=0, delaying=0, imem_addr=0 immediately. No valid until `enable` is sampled after release.
- Wrap: wrap_bottom=1, wrap_top=3, memory of all-zero delays, enable held, no stall -> pc sequence 0,1,2,3,1,2,3,1 on consecutive cycles.
- Jump: `instr` at pc=2 accepted with jmp_valid=1, jmp_target=9 -> imem_addr=9 that cycle; next cycle pc=9, instr=mem[9], no bubble.
- Delay: SIDESET_BITS=0, mem[0][12:8]=3 -> valid for mem[0] is followed by 3 cycles of valid=0 (delaying=1), then mem[1]. With SIDESET_BITS=2 and field 5'b11011 -> delay 3.
- Stall: stall=1 for 4 cycles with mem[4] held -> instr, pc and valid are stable. After release, mem[5] follows the next cycle.
- Enable/restart: drop `enable` while mem[6] is held and unaccepted -> valid=0. Re-enable -> mem[6] is refetched. A restart pulse -> pc=0, IDLE; with enable high, mem[0] is valid 1 cycle later.
